multicycle_controller: RTL and testbench

Multi-cycle control unit for the Minisys MIPS CPU. It is the parametrised successor of the single-cycle decoder. The instruction opcode and function fields are decoded combinationally, and every architectural strobe is sequenced through a FETCH/DECODE/EXEC/MEM/WB state machine. A ready handshake lets instruction and data memory take variable latency, and an optional watchdog aborts hung accesses. A retired-instruction counter is included.

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Controller bundle: IR fields and memory handshake in, sequencing strobes and status out.
interface multicycle_controller_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic               mem_to_reg;
  logic               alu_src;
  logic [1:0]         alu_op;
  logic               i_format;
  logic               sftmd;
  logic               jr;
  logic               jmp;
  logic               jal;
  logic               branch;
  logic [2:0]         state;
  logic               instr_done;
  logic               bus_error;
  logic               illegal;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src, alu_op, i_format, sftmd, jr, jmp, jal, branch, state,
           instr_done, bus_error, illegal, instr_count
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src, alu_op, i_format, sftmd, jr, jmp, jal, branch, state,
           instr_done, bus_error, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Minisys multi-cycle control unit: combinational decode, FETCH/DECODE/EXEC/MEM/WB sequencer,
// memory-wait watchdog and retired-instruction counter. Strobes are Mealy, same cycle.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit FAST_JUMP   = 1'b1,
  parameter int COUNT_W     = 32
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int              WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              WD_EN   = (MEM_TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WD_W-1:0]    r_wd;
  logic               r_bus_error;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;

  logic w_r_format, w_i_format, w_jr, w_jmp, w_jal, w_beq, w_bne, w_lw, w_sw;
  logic w_sftmd, w_legal, w_jump;
  logic w_waiting, w_timeout;
  logic w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  logic [1:0] w_reg_dst;
  logic w_mem_to_reg, w_alu_src, w_done, w_abort, w_illegal;

  assign w_r_format = (bus.opcode == 6'h00);
  assign w_i_format = (bus.opcode[5:3] == 3'b001);
  assign w_jr       = w_r_format && (bus.funct == 6'h08);
  assign w_jmp      = (bus.opcode == 6'h02);
  assign w_jal      = (bus.opcode == 6'h03);
  assign w_beq      = (bus.opcode == 6'h04);
  assign w_bne      = (bus.opcode == 6'h05);
  assign w_lw       = (bus.opcode == 6'h23);
  assign w_sw       = (bus.opcode == 6'h2B);
  assign w_sftmd    = w_r_format && (bus.funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
  assign w_legal    = w_r_format | w_i_format | w_jmp | w_jal | w_beq | w_bne | w_lw | w_sw;
  assign w_jump     = w_jmp | w_jal | w_jr;

  // Completion on the last allowed wait cycle wins over the abort.
  assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
  assign w_timeout  = WD_EN && w_waiting && (r_wd == WD_LAST);

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 2'd0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else if (FAST_JUMP && w_jump) begin
          w_pc_write = 1'b1;
          w_done     = 1'b1;
          if (w_jal) begin
            w_reg_write = 1'b1;
            w_reg_dst   = 2'd2;
          end
          w_next = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_src = w_i_format | w_lw | w_sw;
        if (w_beq || w_bne) begin
          w_pc_write = w_beq ? bus.zero : !bus.zero;
          w_done     = 1'b1;
          w_next     = S_FETCH;
        end else if (w_jump) begin
          w_pc_write = 1'b1;
          w_done     = 1'b1;
          if (w_jal) begin
            w_reg_write = 1'b1;
            w_reg_dst   = 2'd2;
          end
          w_next = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_read  = w_lw;
        w_mem_write = w_sw;
        if (bus.mem_ready) begin
          w_done = w_sw;
          w_next = w_sw ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_lw;
        w_reg_dst    = w_r_format ? 2'd1 : 2'd0;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_wd        <= '0;
      r_bus_error <= 1'b0;
      r_illegal   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_bus_error <= w_abort;
      r_illegal   <= w_illegal;
      if ((w_next != r_state) || w_abort) begin
        r_wd <= '0;
      end else if (WD_EN && w_waiting) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_done) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Strobes are squashed during reset so an interrupted write never reaches memory.
  assign bus.pc_write    = w_pc_write   & ~reset;
  assign bus.ir_write    = w_ir_write   & ~reset;
  assign bus.mem_read    = w_mem_read   & ~reset;
  assign bus.mem_write   = w_mem_write  & ~reset;
  assign bus.reg_write   = w_reg_write  & ~reset;
  assign bus.reg_dst     = reset ? 2'd0 : w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg & ~reset;
  assign bus.alu_src     = w_alu_src    & ~reset;
  assign bus.instr_done  = w_done       & ~reset;

  assign bus.alu_op      = {w_r_format | w_i_format, w_beq | w_bne};
  assign bus.i_format    = w_i_format;
  assign bus.sftmd       = w_sftmd;
  assign bus.jr          = w_jr;
  assign bus.jmp         = w_jmp;
  assign bus.jal         = w_jal;
  assign bus.branch      = w_beq;
  assign bus.state       = r_state;
  assign bus.bus_error   = r_bus_error;
  assign bus.illegal     = r_illegal;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: DUT A (timeout 4, fast jumps, 4-bit counter) then DUT B (slow jumps); per-cycle scoreboard.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] f;
  } obs_t;

  localparam logic [11:0] PCW  = 12'h800;
  localparam logic [11:0] IRW  = 12'h400;
  localparam logic [11:0] MRD  = 12'h200;
  localparam logic [11:0] MWR  = 12'h100;
  localparam logic [11:0] RW   = 12'h080;
  localparam logic [11:0] RD2  = 12'h040;
  localparam logic [11:0] RD1  = 12'h020;
  localparam logic [11:0] M2R  = 12'h010;
  localparam logic [11:0] ASRC = 12'h008;
  localparam logic [11:0] DONE = 12'h004;
  localparam logic [11:0] BERR = 12'h002;
  localparam logic [11:0] ILL  = 12'h001;
  localparam logic [11:0] FET  = MRD | IRW | PCW;
  localparam logic [2:0]  FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4;

  logic       clk = 1'b0;
  logic       sel, s_rst, rst_a, rst_b, zero, mem_ready;
  logic [5:0] opcode, funct;

  always #5 clk = ~clk;

  multicycle_controller_if #(.COUNT_W(4))  ifa();
  multicycle_controller_if #(.COUNT_W(32)) ifb();

  assign rst_a = sel ? 1'b1 : s_rst;
  assign rst_b = sel ? s_rst : 1'b1;
  assign ifa.opcode = opcode;
  assign ifa.funct = funct;
  assign ifa.zero = zero;
  assign ifa.mem_ready = mem_ready;
  assign ifb.opcode = opcode;
  assign ifb.funct = funct;
  assign ifb.zero = zero;
  assign ifb.mem_ready = mem_ready;

  multicycle_controller #(.MEM_TIMEOUT(4), .FAST_JUMP(1'b1), .COUNT_W(4)) dut_a (
    .clock(clk), .reset(rst_a), .bus(ifa.slave)
  );
  multicycle_controller #(.MEM_TIMEOUT(15), .FAST_JUMP(1'b0), .COUNT_W(32)) dut_b (
    .clock(clk), .reset(rst_b), .bus(ifb.slave)
  );

  obs_t obs_a, obs_b, obs;
  logic [7:0]  dec_a, dec_b, dec_obs;
  logic [31:0] cnt_obs;

  assign obs_a = {ifa.state, ifa.pc_write, ifa.ir_write, ifa.mem_read, ifa.mem_write, ifa.reg_write,
                  ifa.reg_dst, ifa.mem_to_reg, ifa.alu_src, ifa.instr_done, ifa.bus_error, ifa.illegal};
  assign obs_b = {ifb.state, ifb.pc_write, ifb.ir_write, ifb.mem_read, ifb.mem_write, ifb.reg_write,
                  ifb.reg_dst, ifb.mem_to_reg, ifb.alu_src, ifb.instr_done, ifb.bus_error, ifb.illegal};
  assign dec_a = {ifa.jr, ifa.jmp, ifa.jal, ifa.branch, ifa.i_format, ifa.sftmd, ifa.alu_op};
  assign dec_b = {ifb.jr, ifb.jmp, ifb.jal, ifb.branch, ifb.i_format, ifb.sftmd, ifb.alu_op};
  assign obs     = sel ? obs_b : obs_a;
  assign dec_obs = sel ? dec_b : dec_a;
  assign cnt_obs = sel ? ifb.instr_count : {28'd0, ifa.instr_count};

  obs_t       exp_q[$];
  logic [2:0] stim_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Queue one cycle: expected state/strobes plus the reset, mem_ready and zero inputs for that cycle.
  task automatic p(input logic [2:0] st, input logic [11:0] f, input logic rdy, input logic z,
                   input logic r);
    obs_t e;
    e.st = st;
    e.f  = f;
    exp_q.push_back(e);
    stim_q.push_back({r, rdy, z});
  endtask

  task automatic run(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      logic [2:0] s;
      obs_t       e;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      s_rst = s[2];
      mem_ready = s[1];
      zero = s[0];
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(e));
      i++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cnt(input int e, input string tag);
    check(tag, cnt_obs, 32'(e));
  endtask

  task automatic dec(input logic [5:0] o, input logic [5:0] fn, input logic [7:0] e, input string tag);
    opcode = o;
    funct = fn;
    #1;
    check(tag, 32'(dec_obs), 32'(e));
  endtask

  initial begin
    sel = 1'b0; s_rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 6'h00; funct = 6'h21;
    @(posedge clk);
    #1;

    p(FE, 0, 1, 0, 1); p(FE, 0, 1, 0, 1); run("reset"); cnt(0, "cnt_reset");

    opcode = 6'h00; funct = 6'h21;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, 0, 1, 0, 0); p(WB, RW | RD1 | DONE, 1, 0, 0);
    run("addu"); cnt(1, "cnt_addu");

    opcode = 6'h23;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, ASRC, 1, 0, 0);
    repeat (3) p(ME, MRD, 0, 0, 0);
    p(ME, MRD, 1, 0, 0); p(WB, RW | M2R | DONE, 1, 0, 0);
    run("lw_wait"); cnt(2, "cnt_lw");

    opcode = 6'h04;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, PCW | DONE, 1, 1, 0); run("beq_z1");
    opcode = 6'h05;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, DONE, 1, 1, 0); run("bne_z1");
    cnt(4, "cnt_branch");

    opcode = 6'h03;
    p(FE, FET, 1, 0, 0); p(DE, PCW | RW | RD2 | DONE, 1, 0, 0); p(FE, MRD, 0, 0, 0);
    run("jal_fast"); cnt(5, "cnt_jal");

    opcode = 6'h2B;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, ASRC, 1, 0, 0);
    p(ME, MWR, 0, 0, 0); p(ME, MWR | DONE, 1, 0, 0);
    run("sw"); cnt(6, "cnt_sw");

    opcode = 6'h08;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, ASRC, 1, 0, 0); p(WB, RW | DONE, 1, 0, 0);
    run("addi"); cnt(7, "cnt_addi");

    opcode = 6'h00; funct = 6'h21;
    repeat (4) p(FE, MRD, 0, 0, 0);
    p(FE, FET | BERR, 1, 0, 0);
    run("fetch_timeout"); cnt(7, "cnt_after_abort");
    p(DE, 0, 1, 0, 0); p(EX, 0, 1, 0, 0); p(WB, RW | RD1 | DONE, 1, 0, 0);
    run("addu_retry"); cnt(8, "cnt_retry");

    opcode = 6'h02;
    repeat (3) p(FE, MRD, 0, 0, 0);
    p(FE, FET, 1, 0, 0); p(DE, PCW | DONE, 1, 0, 0);
    run("fetch_ready_at_limit"); cnt(9, "cnt_limit");

    opcode = 6'h23;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, ASRC, 1, 0, 0);
    repeat (4) p(ME, MRD, 0, 0, 0);
    run("mem_timeout");
    opcode = 6'h3F;
    p(FE, FET | BERR, 1, 0, 0); p(DE, 0, 1, 0, 0);
    run("illegal_dec"); cnt(9, "cnt_illegal");
    opcode = 6'h00; funct = 6'h08;
    p(FE, FET | ILL, 1, 0, 0); p(DE, PCW | DONE, 1, 0, 0);
    run("jr_fast"); cnt(10, "cnt_jr");

    opcode = 6'h02;
    repeat (6) begin
      p(FE, FET, 1, 0, 0); p(DE, PCW | DONE, 1, 0, 0);
    end
    run("wrap"); cnt(0, "cnt_wrap");

    opcode = 6'h2B;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, ASRC, 1, 0, 0);
    p(ME, MWR, 0, 0, 0); p(ME, 0, 0, 0, 1); p(FE, MRD, 0, 0, 0);
    run("sw_reset");

    sel = 1'b1;
    p(FE, 0, 1, 0, 1); run("b_reset"); cnt(0, "b_cnt_reset");

    opcode = 6'h03;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, PCW | RW | RD2 | DONE, 1, 0, 0);
    p(FE, MRD, 0, 0, 0);
    run("b_jal_slow"); cnt(1, "b_cnt_jal");

    opcode = 6'h02;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, PCW | DONE, 1, 0, 0); run("b_j_slow");
    opcode = 6'h00; funct = 6'h08;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, PCW | DONE, 1, 0, 0); run("b_jr_slow");
    cnt(3, "b_cnt_jumps");

    opcode = 6'h23;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, ASRC, 1, 0, 0);
    repeat (5) p(ME, MRD, 0, 0, 0);
    p(ME, MRD, 1, 0, 0); p(WB, RW | M2R | DONE, 1, 0, 0);
    run("b_lw_long"); cnt(4, "b_cnt_lw");

    opcode = 6'h04;
    p(FE, FET, 1, 0, 0); p(DE, 0, 1, 0, 0); p(EX, DONE, 1, 0, 0);
    run("b_beq_z0"); cnt(5, "b_cnt_beq");

    mem_ready = 1'b0;
    dec(6'h00, 6'h21, 8'h02, "dec_addu");
    dec(6'h00, 6'h08, 8'h82, "dec_jr");
    dec(6'h00, 6'h03, 8'h06, "dec_sra");
    dec(6'h02, 6'h00, 8'h40, "dec_j");
    dec(6'h03, 6'h00, 8'h20, "dec_jal");
    dec(6'h04, 6'h00, 8'h11, "dec_beq");
    dec(6'h05, 6'h00, 8'h01, "dec_bne");
    dec(6'h0D, 6'h00, 8'h0A, "dec_ori");
    dec(6'h23, 6'h00, 8'h00, "dec_lw");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
